// File: rtl/present_cipher_core_if.sv
// Host-side bus of the PRESENT cipher core: key load, input block handshake,
// output block handshake and status.
interface present_cipher_core_if #(
  parameter int unsigned KEY_WIDTH = 80
) ();
  logic [KEY_WIDTH-1:0] key_i;
  logic                 key_load_i;
  logic                 key_ready_o;
  logic [63:0]          data_i;
  logic                 mode_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [63:0]          data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 busy_o;

  modport master (
    output key_i, key_load_i, data_i, mode_i, in_valid_i, out_ready_i,
    input  key_ready_o, in_ready_o, data_o, out_valid_o, busy_o
  );

  modport slave (
    input  key_i, key_load_i, data_i, mode_i, in_valid_i, out_ready_i,
    output key_ready_o, in_ready_o, data_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/present_cipher_core.sv
// Iterative PRESENT-80/128 engine, one round per clock, encrypt and decrypt.
// Decryption starts from the last round key, expanded once per key load.
module present_cipher_core #(
  parameter int unsigned KEY_WIDTH      = 80,
  parameter int unsigned ENABLE_DECRYPT = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  present_cipher_core_if.slave bus
);
  localparam int unsigned KW      = KEY_WIDTH;
  localparam int unsigned RC_LO   = (KEY_WIDTH == 128) ? 62 : 15;
  localparam logic        TWO_NIB = (KEY_WIDTH == 128);
  localparam logic        DEC_EN  = (ENABLE_DECRYPT != 0);
  // Nibble i of each table holds S(i) / S^-1(i).
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SINV_TABLE = 64'hA970_364B_D21C_8FE5;

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_KEYEXP, ST_RUN, ST_DONE} fsm_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sinv(input logic [3:0] x);
    return SINV_TABLE[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input logic inv);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[4*i +: 4] = inv ? sinv(s[4*i +: 4]) : sbox(s[4*i +: 4]);
    end
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input logic inv);
    logic [63:0] o;
    int          j;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      j = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) begin
        o[i] = s[j];
      end else begin
        o[j] = s[i];
      end
    end
    return o;
  endfunction

  function automatic logic [KW-1:0] key_fwd(input logic [KW-1:0] k, input logic [4:0] rc);
    logic [KW-1:0] t;
    t = {k[KW-62:0], k[KW-1:KW-61]};
    t[KW-1:KW-4] = sbox(t[KW-1:KW-4]);
    t[KW-5:KW-8] = TWO_NIB ? sbox(t[KW-5:KW-8]) : t[KW-5:KW-8];
    t[RC_LO+4:RC_LO] = t[RC_LO+4:RC_LO] ^ rc;
    return t;
  endfunction

  function automatic logic [KW-1:0] key_inv(input logic [KW-1:0] k, input logic [4:0] rc);
    logic [KW-1:0] t;
    t = k;
    t[RC_LO+4:RC_LO] = t[RC_LO+4:RC_LO] ^ rc;
    t[KW-1:KW-4] = sinv(t[KW-1:KW-4]);
    t[KW-5:KW-8] = TWO_NIB ? sinv(t[KW-5:KW-8]) : t[KW-5:KW-8];
    return {t[60:0], t[KW-1:61]};
  endfunction

  fsm_t          fsm_r;
  logic [63:0]   state_r;
  logic [63:0]   data_r;
  logic [KW-1:0] key_r;
  logic [KW-1:0] k1_r;
  logic [KW-1:0] k32_r;
  logic [5:0]    round_r;
  logic          mode_r;
  logic          key_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic [63:0]   rk_s;
  logic [63:0]   round_s;
  logic [4:0]    rc_s;
  logic [KW-1:0] key_next_s;
  logic [KW-1:0] kexp_s;
  logic          in_ready_s;
  logic          mode_in_s;

  assign in_ready_s = (fsm_r == ST_IDLE) && key_ready_r && !bus.key_load_i;
  assign mode_in_s  = bus.mode_i & DEC_EN;
  assign kexp_s     = key_fwd(key_r, round_r[4:0]);

  // One cipher round and the matching key step for the current RUN cycle.
  always_comb begin
    rk_s = key_r[KW-1:KW-64];
    if (mode_r) begin
      // Decrypt walks the counter 31..1; -r mod 32 maps step 1 to 31.
      rc_s       = 5'd0 - round_r[4:0];
      round_s    = s_layer(p_layer(state_r ^ rk_s, 1'b1), 1'b1);
      key_next_s = key_inv(key_r, rc_s);
    end else begin
      rc_s       = round_r[4:0];
      round_s    = p_layer(s_layer(state_r ^ rk_s, 1'b0), 1'b0);
      key_next_s = key_fwd(key_r, rc_s);
    end
  end

  // Control FSM with cipher state, key registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_r       <= ST_IDLE;
      state_r     <= 64'd0;
      data_r      <= 64'd0;
      key_r       <= '0;
      k1_r        <= '0;
      k32_r       <= '0;
      round_r     <= 6'd0;
      mode_r      <= 1'b0;
      key_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (bus.key_load_i) begin
            k1_r    <= bus.key_i;
            key_r   <= bus.key_i;
            round_r <= 6'd1;
            if (DEC_EN) begin
              key_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              fsm_r       <= ST_KEYEXP;
            end else begin
              key_ready_r <= 1'b1;
            end
          end else if (bus.in_valid_i && in_ready_s) begin
            state_r <= bus.data_i;
            mode_r  <= mode_in_s;
            key_r   <= mode_in_s ? k32_r : k1_r;
            round_r <= 6'd1;
            busy_r  <= 1'b1;
            fsm_r   <= ST_RUN;
          end
        end
        ST_KEYEXP: begin
          key_r <= kexp_s;
          if (round_r == 6'd31) begin
            k32_r       <= kexp_s;
            key_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            round_r     <= 6'd0;
            fsm_r       <= ST_IDLE;
          end else begin
            round_r <= round_r + 6'd1;
          end
        end
        ST_RUN: begin
          if (round_r == 6'd32) begin
            data_r      <= state_r ^ rk_s;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            round_r     <= 6'd0;
            fsm_r       <= ST_DONE;
          end else begin
            state_r <= round_s;
            key_r   <= key_next_s;
            round_r <= round_r + 6'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            out_valid_r <= 1'b0;
            fsm_r       <= ST_IDLE;
          end
        end
        default: begin
          fsm_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_o      = data_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.key_ready_o = key_ready_r;
  assign bus.busy_o      = busy_r;
  assign bus.in_ready_o  = in_ready_s;
endmodule

// File: tb/tb_present_cipher_core.sv
// Scoreboard bench for present_cipher_core: 80-bit and 128-bit instances driven
// with known-answer vectors; a monitor pops expected blocks on each output handshake.
module tb_present_cipher_core;
  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned acc80 = 0;
  int unsigned acc128 = 0;
  logic        prev80 = 1'b0;
  logic        prev128 = 1'b0;
  logic [63:0] q80[$];
  logic [63:0] q128[$];

  present_cipher_core_if #(.KEY_WIDTH(80))  b80 ();
  present_cipher_core_if #(.KEY_WIDTH(128)) b128 ();

  present_cipher_core #(.KEY_WIDTH(80), .ENABLE_DECRYPT(1)) u80 (
    .clk_i(clk), .rst_i(rst), .bus(b80.slave));
  present_cipher_core #(.KEY_WIDTH(128), .ENABLE_DECRYPT(1)) u128 (
    .clk_i(clk), .rst_i(rst), .bus(b128.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 80-bit monitor: latency from accept and data at each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (b80.in_valid_i && b80.in_ready_o) acc80 = cyc + 1;
      if (b80.out_valid_o && !prev80) check("latency80", 64'(cyc - acc80), 64'd32);
      if (b80.out_valid_o && b80.out_ready_i) begin
        if (q80.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious80: got output %h, want no output", b80.data_o);
        end else begin
          check("data80", b80.data_o, q80.pop_front());
        end
      end
    end
    prev80 = b80.out_valid_o;
  end

  // 128-bit monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (b128.in_valid_i && b128.in_ready_o) acc128 = cyc + 1;
      if (b128.out_valid_o && !prev128) check("latency128", 64'(cyc - acc128), 64'd32);
      if (b128.out_valid_o && b128.out_ready_i) begin
        if (q128.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious128: got output %h, want no output", b128.data_o);
        end else begin
          check("data128", b128.data_o, q128.pop_front());
        end
      end
    end
    prev128 = b128.out_valid_o;
  end

  task automatic wait_ready80();
    int unsigned n = 0;
    while (!b80.in_ready_o && n < 100) begin tick(); n++; end
    if (!b80.in_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL ready80_timeout: in_ready_o=%b, want 1", b80.in_ready_o);
    end
  endtask

  task automatic wait_ready128();
    int unsigned n = 0;
    while (!b128.in_ready_o && n < 100) begin tick(); n++; end
    if (!b128.in_ready_o) begin
      n_vec++; n_err++;
      $display("FAIL ready128_timeout: in_ready_o=%b, want 1", b128.in_ready_o);
    end
  endtask

  task automatic drain80();
    int unsigned n = 0;
    while (q80.size() != 0 && n < 100) begin tick(); n++; end
    if (q80.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain80_timeout: %0d blocks pending, want 0", q80.size());
      q80.delete();
    end
  endtask

  task automatic drain128();
    int unsigned n = 0;
    while (q128.size() != 0 && n < 100) begin tick(); n++; end
    if (q128.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain128_timeout: %0d blocks pending, want 0", q128.size());
      q128.delete();
    end
  endtask

  task automatic load80(input logic [79:0] k);
    b80.key_i = k;
    b80.key_load_i = 1'b1;
    tick();
    b80.key_load_i = 1'b0;
    wait_ready80();
  endtask

  task automatic load128(input logic [127:0] k);
    b128.key_i = k;
    b128.key_load_i = 1'b1;
    tick();
    b128.key_load_i = 1'b0;
    wait_ready128();
  endtask

  task automatic block80(input logic [63:0] d, input logic m, input logic [63:0] exp,
                         input logic pulse, input logic [79:0] pulse_key);
    wait_ready80();
    b80.data_i = d;
    b80.mode_i = m;
    b80.in_valid_i = 1'b1;
    q80.push_back(exp);
    tick();
    b80.in_valid_i = 1'b0;
    if (pulse) begin
      repeat (10) tick();
      b80.key_i = pulse_key;
      b80.key_load_i = 1'b1;
      tick();
      b80.key_load_i = 1'b0;
    end
    drain80();
  endtask

  task automatic block128(input logic [63:0] d, input logic m, input logic [63:0] exp);
    wait_ready128();
    b128.data_i = d;
    b128.mode_i = m;
    b128.in_valid_i = 1'b1;
    q128.push_back(exp);
    tick();
    b128.in_valid_i = 1'b0;
    drain128();
  endtask

  task automatic check_reset_state();
    check("rst_data80",   b80.data_o, 64'd0);
    check("rst_valid80",  64'(b80.out_valid_o), 64'd0);
    check("rst_kready80", 64'(b80.key_ready_o), 64'd0);
    check("rst_busy80",   64'(b80.busy_o), 64'd0);
    check("rst_iready80", 64'(b80.in_ready_o), 64'd0);
    check("rst_data128",  b128.data_o, 64'd0);
    check("rst_valid128", 64'(b128.out_valid_o), 64'd0);
    check("rst_kready128", 64'(b128.key_ready_o), 64'd0);
    check("rst_busy128",  64'(b128.busy_o), 64'd0);
    check("rst_iready128", 64'(b128.in_ready_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b1;
    b80.key_i = '0;  b80.key_load_i = 1'b0;  b80.data_i = 64'd0;  b80.mode_i = 1'b0;
    b80.in_valid_i = 1'b0;  b80.out_ready_i = 1'b1;
    b128.key_i = '0; b128.key_load_i = 1'b0; b128.data_i = 64'd0; b128.mode_i = 1'b0;
    b128.in_valid_i = 1'b0; b128.out_ready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state();

    // Known-answer vectors, 80-bit key.
    load80({80{1'b0}});
    block80(64'h0000000000000000, 1'b0, 64'h5579C1387B228445, 1'b0, '0);
    block80(64'h5579C1387B228445, 1'b1, 64'h0000000000000000, 1'b0, '0);
    block80(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hA112FFC72F68417B, 1'b0, '0);
    block80(64'hA112FFC72F68417B, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0);
    load80({80{1'b1}});
    block80(64'h0000000000000000, 1'b0, 64'hE72C46C0F5945049, 1'b0, '0);
    block80(64'hE72C46C0F5945049, 1'b1, 64'h0000000000000000, 1'b0, '0);
    block80(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h3333DCD3213210D2, 1'b0, '0);
    block80(64'h3333DCD3213210D2, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0);

    // Known-answer vectors, 128-bit key.
    load128({128{1'b0}});
    block128(64'h0000000000000000, 1'b0, 64'h96DB702A2E6900AF);
    block128(64'h96DB702A2E6900AF, 1'b1, 64'h0000000000000000);
    load128({128{1'b1}});
    block128(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h628D9FBD4218E5B4);
    block128(64'h628D9FBD4218E5B4, 1'b1, 64'hFFFFFFFFFFFFFFFF);

    // Key expansion window: a pending input block must not be taken.
    b80.key_i = {80{1'b0}};
    b80.key_load_i = 1'b1;
    b80.data_i = 64'h0123456789ABCDEF;
    b80.in_valid_i = 1'b1;
    tick();
    b80.key_load_i = 1'b0;
    for (int i = 0; i < 31; i++) begin
      check("kexp_kready", 64'(b80.key_ready_o), 64'd0);
      check("kexp_iready", 64'(b80.in_ready_o), 64'd0);
      check("kexp_busy", 64'(b80.busy_o), 64'd1);
      tick();
    end
    b80.in_valid_i = 1'b0;
    check("kexp_done_kready", 64'(b80.key_ready_o), 64'd1);
    check("kexp_done_busy", 64'(b80.busy_o), 64'd0);

    // Key load during RUN is ignored; stored K1/K32 persist.
    block80(64'h0000000000000000, 1'b0, 64'h5579C1387B228445, 1'b1, {80{1'b1}});
    block80(64'h0000000000000000, 1'b0, 64'h5579C1387B228445, 1'b0, '0);
    block80(64'h5579C1387B228445, 1'b1, 64'h0000000000000000, 1'b0, '0);

    // Output back-pressure: result held, no new input accepted.
    b80.out_ready_i = 1'b0;
    wait_ready80();
    b80.data_i = 64'hFFFFFFFFFFFFFFFF;
    b80.mode_i = 1'b0;
    b80.in_valid_i = 1'b1;
    q80.push_back(64'hA112FFC72F68417B);
    tick();
    b80.in_valid_i = 1'b0;
    n = 0;
    while (!b80.out_valid_o && n < 100) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(b80.out_valid_o), 64'd1);
      check("hold_data", b80.data_o, 64'hA112FFC72F68417B);
      check("hold_iready", 64'(b80.in_ready_o), 64'd0);
      tick();
    end
    b80.out_ready_i = 1'b1;
    tick();
    check("release_valid", 64'(b80.out_valid_o), 64'd0);
    check("release_iready", 64'(b80.in_ready_o), 64'd1);
    drain80();

    // Reset in the middle of a block, then reload and rerun.
    wait_ready80();
    b80.data_i = 64'd0;
    b80.mode_i = 1'b0;
    b80.in_valid_i = 1'b1;
    tick();
    b80.in_valid_i = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state();
    load80({80{1'b0}});
    block80(64'h0000000000000000, 1'b0, 64'h5579C1387B228445, 1'b0, '0);
    load128({128{1'b0}});
    block128(64'h0000000000000000, 1'b0, 64'h96DB702A2E6900AF);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
